// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by both the RX and TX sides.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   // Clocks per oversample tick, rounded to nearest.
   function automatic int calc_div(input int clock_freq, input int baud_rate);
      return (clock_freq + (OVERSAMPLE / 2) * baud_rate) / (OVERSAMPLE * baud_rate);
   endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Received-byte handshake: the receiver drives data/valid, the consumer drives ready.
interface uart_byte_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks.
// Latency: first tick DIV clocks after clear deasserts.
// Backpressure: none; clear holds the phase at zero.
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = !clear && (cnt == CW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling and a valid/ready byte output.
// Latency: byte presented 1 clk after the stop-bit mid-sample.
// Backpressure: one byte held; a byte completing while it is unconsumed is dropped with overrun.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 9600
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           uart_rx,
   uart_byte_rx_if.master rx,
   output logic           frame_err,
   output logic           overrun,
   output logic           busy
);

   localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);

   generate
      if (DIV < 1) begin : g_div_check
         $error("uart_byte_rx: CLOCK_FREQ too low for BAUD_RATE, DIV < 1");
      end
   endgenerate

   rx_state_t  state, state_nxt;
   logic [3:0] tick_cnt, tick_cnt_nxt;
   logic [2:0] bit_idx, bit_idx_nxt;
   logic [7:0] shift, shift_nxt;
   logic       rx_meta, rx_sync;
   logic       tick;
   logic       deliver;
   logic       stop_low;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
      end
   end

   // Holding the divider in clear while idle re-phases ticks to each start edge.
   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (state == IDLE),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         state    <= state_nxt;
         tick_cnt <= tick_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shift    <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tick_cnt_nxt = tick_cnt;
      bit_idx_nxt  = bit_idx;
      shift_nxt    = shift;
      deliver      = 1'b0;
      stop_low     = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_sync) begin
               state_nxt    = START;
               tick_cnt_nxt = '0;
            end
         end
         START: begin
            if (tick) begin
               if (tick_cnt == 4'd7) begin
                  tick_cnt_nxt = '0;
                  bit_idx_nxt  = '0;
                  state_nxt    = rx_sync ? IDLE : DATA;
               end else begin
                  tick_cnt_nxt = tick_cnt + 4'd1;
               end
            end
         end
         DATA: begin
            // tick_cnt wraps 15 -> 0, so every 16th tick lands mid-bit.
            if (tick) begin
               tick_cnt_nxt = tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) begin
                  shift_nxt = {rx_sync, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     state_nxt = STOP;
                  end else begin
                     bit_idx_nxt = bit_idx + 3'd1;
                  end
               end
            end
         end
         STOP: begin
            if (tick) begin
               tick_cnt_nxt = tick_cnt + 4'd1;
               if (tick_cnt == 4'd15) begin
                  if (rx_sync) begin
                     deliver   = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     stop_low  = 1'b1;
                     state_nxt = WAIT_HIGH;
                  end
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_sync) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx.rx_data  <= '0;
         rx.rx_valid <= 1'b0;
         frame_err   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         frame_err <= stop_low;
         overrun   <= 1'b0;
         if (deliver) begin
            // A handshake in the delivery cycle frees the slot for the new byte.
            if (!rx.rx_valid || rx.rx_ready) begin
               rx.rx_data  <= shift;
               rx.rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx.rx_valid && rx.rx_ready) begin
            rx.rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
